// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator feeding a DEPTH-entry {pc, inst} queue toward ID.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         inst_ren,
  output logic [ADDR_W-1:0]            inst_addr,
  input  logic                         inst_ack,
  input  logic [DATA_W-1:0]            inst_data,
  input  logic                         redirect_en,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         id_en,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_inst,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ADDR_W-1:0]            out_pc_next,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     wp, rp;
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [DATA_W-1:0] q_inst [DEPTH];
  logic              pop, push;
  assign out_valid   = count != '0;
  assign pop         = out_valid & id_en & ~redirect_en;
  assign inst_ren    = rst_n & ~redirect_en & ((count < FULL) | pop);
  assign push        = inst_ren & inst_ack;
  assign inst_addr   = pc;
  assign out_inst    = out_valid ? q_inst[rp] : '0;
  assign out_pc      = out_valid ? q_pc[rp] : '0;
  assign out_pc_next = out_valid ? q_pc[rp] + ADDR_W'(4) : '0;
  // storage is qualified by count, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wp]   <= pc;
      q_inst[wp] <= inst_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (redirect_en) begin
      pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc <= pc + ADDR_W'(4);
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- ADDR_W, 32, PC width.
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries; must be a power of 2 and at least 2.
- RESET_PC, 0, fetch address after reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- inst_ren, out, 1, instruction read request.
- inst_addr, out, ADDR_W, fetch PC.
- inst_ack, in, 1, memory accepts the request; inst_data is valid in the same cycle.
- inst_data, in, DATA_W, fetched instruction.
- redirect_en, in, 1, branch/jump taken from MEM.
- redirect_pc, in, ADDR_W, branch target.
- id_en, in, 1, ID stage accepts the head entry.
- out_valid, out, 1, head entry valid.
- out_inst, out, DATA_W, head instruction.
- out_pc, out, ADDR_W, head PC.
- out_pc_next, out, ADDR_W, head PC+4.
- count, out, $clog2(DEPTH+1), occupancy.

Function
REQ-004 The block SHALL hold a fetch PC register (pc) and a circular queue of DEPTH entries, each entry being {pc, inst}.
REQ-005 The block SHALL define pop = out_valid & id_en & ~redirect_en.
REQ-006 inst_ren SHALL be combinational and equal to rst_n & ~redirect_en & (count<DEPTH | pop).
REQ-007 inst_addr SHALL equal pc.
REQ-008 A push SHALL occur when inst_ren & inst_ack: {pc, inst_data} is written at the write pointer, and pc <= pc+4 modulo 2^ADDR_W (0xFFFFFFFC wraps to 0).
REQ-009 A push with inst_ack low SHALL NOT occur; pc SHALL hold and the request SHALL repeat next cycle.
REQ-010 out_valid SHALL equal (count!=0).
REQ-011 out_inst and out_pc SHALL be the head entry; out_pc_next SHALL be out_pc+4.
REQ-012 When out_valid is 0, out_inst, out_pc and out_pc_next SHALL be 0.
REQ-013 Latency: an instruction pushed at edge N SHALL appear as the head no earlier than the cycle after edge N; there is no bypass from inst_data to out_inst.
REQ-014 A pop SHALL advance the read pointer by 1 modulo DEPTH.
REQ-015 Push and pop SHALL be allowed in the same cycle, including when count==DEPTH; count SHALL then be unchanged.
REQ-016 count SHALL be updated as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-017 count SHALL never exceed DEPTH and SHALL never underflow.
REQ-018 With count==DEPTH and no pop, inst_ren SHALL be 0 and pc SHALL hold.
REQ-019 With count==0, id_en SHALL be ignored.
REQ-020 redirect_en SHALL take priority over all other events. On the next edge: pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; both pointers and count are cleared; no push and no pop take effect.
REQ-021 The first post-redirect request SHALL be issued in the cycle after the redirect edge, with inst_addr equal to the aligned target.
REQ-022 Back-to-back redirects SHALL each take effect, the last one winning; the queue SHALL stay empty throughout.
REQ-023 The pointers SHALL be log2(DEPTH) bits wide and wrap naturally; full/empty SHALL be decided by count, not by pointer equality.

Reset
REQ-024 While rst_n==0: pc=RESET_PC, pointers=0, count=0, out_valid=0, inst_ren=0, out_inst/out_pc/out_pc_next=0.
REQ-025 Reset SHALL act immediately and asynchronously, including mid-operation, and SHALL discard all queued entries.
REQ-026 Queue storage SHALL need no reset.
REQ-027 The first request after rst_n rises SHALL be inst_addr=RESET_PC.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset release, inst_ack=1, id_en=0, DEPTH=4 -> pushes at PCs 0x0, 0x4, 0x8, 0xC; count=4; inst_ren=0; pc=0x10 holds.
- Full queue, then id_en=1 with inst_ack=1 -> simultaneous push/pop each cycle; count stays 4; out_pc steps 0x0, 0x4, 0x8, ...
- Redirect with redirect_pc=0x1003 while count=3 -> next cycle count=0, out_valid=0, inst_addr=0x1000; out_pc=0x1000 the cycle after the first push.
- inst_ack toggling 1,0,1 from empty with id_en=1 -> exactly 2 entries delivered, PCs consecutive, no duplicate and no skip.
- pc=0xFFFFFFFC push -> next inst_addr=0x00000000; out_pc_next of that entry is 0x0.
- rst_n pulsed low mid-stream with count=2 -> out_valid drops asynchronously; after release inst_addr=RESET_PC and count=0.
